ssd_driver: RTL
===============

SSD_DRIVER -- requirements
Module: ssd_driver

Interface
REQ-001 Parameter: REFRESH_DIV, 100000, clock cycles each digit is held during the display scan (minimum 2).
REQ-002 Port: clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: load  input  1  request to capture a new value.
REQ-005 Port: sum  input  8  unsigned magnitude to display, 0..255.
REQ-006 Port: neg  input  1  sign of the magnitude (1 = negative).
REQ-007 Port: busy  output  1  conversion in progress; load is ignored while high.
REQ-008 Port: an  output  4  digit enables, active-low; an[0] = units, an[3] = sign position.
REQ-009 Port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 Port: dp  output  1  decimal point, active-low; always 1 (off).

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and COMMIT.
REQ-012 In IDLE, load=1 at a rising edge SHALL capture sum and neg, clear the BCD accumulator, set busy=1 and enter SHIFT.
REQ-013 SHIFT SHALL run a sequential double-dabble conversion of exactly 8 cycles, one bit per cycle, MSB first, with add-3 on any BCD nibble >=5 before each shift.
REQ-014 After the 8th SHIFT cycle the FSM SHALL enter COMMIT for 1 cycle.
REQ-015 The edge leaving COMMIT SHALL write the hundreds, tens, units and sign into the display registers, clear busy and return to IDLE.
REQ-016 Busy SHALL be high for exactly 9 cycles per accepted load; the display registers SHALL change only at the COMMIT exit edge.
REQ-017 load while busy=1 SHALL be ignored and not queued; load held high SHALL retrigger on the first IDLE edge.
REQ-018 A free-running prescaler SHALL count 0..REFRESH_DIV-1.
REQ-019 At each prescaler wrap, the digit index SHALL advance 0->1->2->3->0, and an/seg SHALL be registered for the new index with exactly one an bit low.
REQ-020 Segment codes (hex, active-low) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, minus=3F, blank=7F.
REQ-021 Digit 0 SHALL always show the units value.
REQ-022 Digit 1 SHALL show blank when hundreds=0 and tens=0; otherwise it SHALL show tens.
REQ-023 Digit 2 SHALL show blank when hundreds=0; otherwise it SHALL show hundreds.
REQ-024 Digit 3 SHALL show minus when neg=1 and the value is nonzero; otherwise it SHALL show blank (negative zero displays "0").
REQ-025 The scan SHALL continue uninterrupted during conversion and SHALL show the previous committed value until the COMMIT exit edge.
REQ-026 sum=255 SHALL convert without overflow; the BCD accumulator SHALL be 12 bits wide.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, busy=0, an=4'b1111, seg=7'h7F, dp=1, prescaler=0, digit index=0, and display registers = value 0, sign positive.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion with no display update.
REQ-029 After reset release, an SHALL remain 1111 until the first prescaler wrap, after which digit 0 SHALL show 7'h40.
REQ-030 load coincident with the reset release edge SHALL be ignored.

Verification (REFRESH_DIV=4 on the bench)
REQ-031 Scan: after reset, idle -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles; seg = 40, 7F, 7F, 7F.
REQ-032 Conversion: load sum=62, neg=0 -> busy high 9 cycles; digits then show units 24, tens 02, hundreds 7F, sign 7F.
REQ-033 Full range: load sum=255, neg=1 -> digits 12, 12, 24, 3F.
REQ-034 Busy drop: load sum=105, then load sum=7 three cycles later -> display 105 (digits 12, 40, 79, 7F) and busy pulse of 9 cycles only.
REQ-035 Negative zero: load sum=0, neg=1 -> digits 40, 7F, 7F, 7F.
REQ-036 Reset abort: load sum=200, assert rst at SHIFT cycle 4 -> outputs reach reset values at once; after release, display shows 0 and busy=0.

Source files
------------

// File: rtl/ssd_driver.sv
// Four-digit seven-segment driver: converts a signed 8-bit magnitude to BCD by sequential
// double-dabble and multiplexes units/tens/hundreds/sign onto a common-anode display.
module ssd_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] sum,
    input  logic       neg,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_sr, w_sr_next;
    logic [11:0] r_bcd, w_bcd_next, w_adj;
    logic [2:0]  r_cnt, w_cnt_next;
    logic        r_cap_neg, w_cap_neg_next;
    logic        w_commit;

    logic [3:0]  r_hund, r_tens, r_units;
    logic        r_disp_neg;

    logic [PW-1:0] r_pre;
    logic [1:0]    r_idx;
    logic [3:0]    r_an, w_an_next;
    logic [6:0]    r_seg, w_seg_next;
    logic          w_nonzero;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            default: c = 7'h7F;
        endcase
        return c;
    endfunction

    // Add-3 correction on every BCD nibble before the shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_sr_next      = r_sr;
        w_bcd_next     = r_bcd;
        w_cnt_next     = r_cnt;
        w_cap_neg_next = r_cap_neg;
        w_commit       = 1'b0;
        case (r_state)
            StIdle: begin
                if (load) begin
                    w_sr_next      = sum;
                    w_cap_neg_next = neg;
                    w_bcd_next     = '0;
                    w_cnt_next     = '0;
                    w_state_next   = StShift;
                end
            end
            StShift: begin
                w_bcd_next = {w_adj[10:0], r_sr[7]};
                w_sr_next  = {r_sr[6:0], 1'b0};
                w_cnt_next = r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    w_state_next = StCommit;
                end
            end
            StCommit: begin
                w_commit     = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_sr      <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_cap_neg <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sr      <= w_sr_next;
            r_bcd     <= w_bcd_next;
            r_cnt     <= w_cnt_next;
            r_cap_neg <= w_cap_neg_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hund     <= '0;
            r_tens     <= '0;
            r_units    <= '0;
            r_disp_neg <= 1'b0;
        end else if (w_commit) begin
            r_hund     <= r_bcd[11:8];
            r_tens     <= r_bcd[7:4];
            r_units    <= r_bcd[3:0];
            r_disp_neg <= r_cap_neg;
        end
    end

    // r_idx names the digit that the next prescaler wrap will light
    always_comb begin
        w_nonzero  = (r_hund != 4'd0) || (r_tens != 4'd0) || (r_units != 4'd0);
        w_an_next  = ~(4'b0001 << r_idx);
        w_seg_next = 7'h7F;
        case (r_idx)
            2'd0: w_seg_next = seg_code(r_units);
            2'd1: if (r_hund != 4'd0 || r_tens != 4'd0) w_seg_next = seg_code(r_tens);
            2'd2: if (r_hund != 4'd0) w_seg_next = seg_code(r_hund);
            2'd3: if (r_disp_neg && w_nonzero) w_seg_next = 7'h3F;
            default: w_seg_next = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
            r_an  <= 4'hF;
            r_seg <= 7'h7F;
        end else if (r_pre == PRE_MAX) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign busy = (r_state != StIdle);
    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = 1'b1;

endmodule
